wb_arbiter: RTL

Schedules the single writeback port between the execution units. The ALU, MUL/DIV, branch and LSU pipes each deliver completed `wb_packet_t` beats into a small per-source FIFO. The arbiter picks one beat per cycle and presents it registered on `wb_valid_o`/`wb_packet_o`, which feeds `writeback_module`'s `wb_valid_i`/`wb_packet_i`. On a misprediction recovery it discards every buffered beat younger than the recovering branch.

---
 rtl/wb_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source FIFOs feeding one registered writeback port,
// with branch-first / round-robin grant and misprediction squash by ROB age.
package wb_arbiter_pkg;
    typedef struct packed {
        logic [3:0]  ROB_tag;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [1:0]  src_fu;
    } wb_packet_t;
endpackage

// One source FIFO; head sits at index 0 so a squash is a simple in-order compaction.
module wb_arb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int RIDX_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  wb_packet_t        i_pkt,
    input  logic              i_pop,
    input  logic              i_recover,
    input  logic [RIDX_W-1:0] i_rob_head,
    input  logic [RIDX_W-1:0] i_rec_age,
    output logic              o_ready,
    output logic              o_head_ok,
    output wb_packet_t        o_head
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    wb_packet_t       r_mem [DEPTH];
    logic [CNT_W-1:0] r_cnt;
    wb_packet_t       w_mem_nx [DEPTH];
    logic [CNT_W-1:0] w_cnt_nx;

    // Age is relative to the ROB head, so index wrap falls out of the subtraction.
    function automatic logic f_kill(input logic [3:0] tag);
        logic [RIDX_W-1:0] w_age;
        w_age = tag[RIDX_W-1:0] - i_rob_head;
        return i_recover && (w_age > i_rec_age);
    endfunction

    assign o_ready   = (r_cnt != CNT_W'(DEPTH));
    assign o_head    = r_mem[0];
    assign o_head_ok = (r_cnt != '0) && !f_kill(r_mem[0].ROB_tag);

    always_comb begin
        w_mem_nx = r_mem;
        w_cnt_nx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < r_cnt && !(i_pop && i == 0) && !f_kill(r_mem[i].ROB_tag)) begin
                w_mem_nx[w_cnt_nx[IDX_W-1:0]] = r_mem[i];
                w_cnt_nx = w_cnt_nx + CNT_W'(1);
            end
        end
        if (i_push && !f_kill(i_pkt.ROB_tag) && w_cnt_nx != CNT_W'(DEPTH)) begin
            w_mem_nx[w_cnt_nx[IDX_W-1:0]] = i_pkt;
            w_cnt_nx = w_cnt_nx + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_cnt <= w_cnt_nx;
            r_mem <= w_mem_nx;
        end
    end
endmodule

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int NUM_SRC    = 4,
    parameter  int FIFO_DEPTH = 2,
    parameter  int ROB_DEPTH  = 16,
    parameter  int BR_SRC     = 2,
    localparam int RIDX_W     = $clog2(ROB_DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_SRC-1:0]        in_valid_i,
    input  wb_packet_t [NUM_SRC-1:0]  in_packet_i,
    output logic [NUM_SRC-1:0]        in_ready_o,
    output logic                      wb_valid_o,
    output wb_packet_t                wb_packet_o,
    input  logic                      wb_ready_i,
    input  logic                      recover_i,
    input  logic [3:0]                recover_rob_tag_i,
    input  logic [RIDX_W-1:0]         rob_head_i
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic                     r_out_v;
    wb_packet_t               r_out_pkt;
    logic [SRC_W-1:0]         r_rr;

    logic [NUM_SRC-1:0]       w_push;
    logic [NUM_SRC-1:0]       w_pop;
    logic [NUM_SRC-1:0]       w_head_ok;
    wb_packet_t [NUM_SRC-1:0] w_head;
    logic [RIDX_W-1:0]        w_rec_age;
    logic [RIDX_W-1:0]        w_out_age;
    logic                     w_out_kill;
    logic                     w_load;
    logic                     w_gnt_v;
    logic [SRC_W-1:0]         w_gnt_idx;
    logic [SRC_W-1:0]         w_rr_nx;
    wb_packet_t               w_gnt_pkt;

    assign w_rec_age  = recover_rob_tag_i[RIDX_W-1:0] - rob_head_i;
    assign w_out_age  = r_out_pkt.ROB_tag[RIDX_W-1:0] - rob_head_i;
    assign w_out_kill = recover_i && (w_out_age > w_rec_age);
    assign w_load     = !r_out_v || wb_ready_i;
    assign w_push     = in_valid_i & in_ready_o;

    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            wb_arb_fifo #(
                .DEPTH  (FIFO_DEPTH),
                .RIDX_W (RIDX_W)
            ) u_fifo (
                .i_clk      (clk_i),
                .i_rst_n    (rst_i),
                .i_push     (w_push[s]),
                .i_pkt      (in_packet_i[s]),
                .i_pop      (w_pop[s]),
                .i_recover  (recover_i),
                .i_rob_head (rob_head_i),
                .i_rec_age  (w_rec_age),
                .o_ready    (in_ready_o[s]),
                .o_head_ok  (w_head_ok[s]),
                .o_head     (w_head[s])
            );
            assign w_pop[s] = w_gnt_v && (w_gnt_idx == SRC_W'(s));
        end
    endgenerate

    // Branch source first; others round-robin from r_rr, which never points at BR_SRC.
    always_comb begin
        int idx;
        int nxt;
        idx       = 0;
        nxt       = 0;
        w_gnt_v   = 1'b0;
        w_gnt_idx = '0;
        w_rr_nx   = r_rr;
        if (w_load) begin
            if (w_head_ok[BR_SRC]) begin
                w_gnt_v   = 1'b1;
                w_gnt_idx = SRC_W'(BR_SRC);
            end else begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    idx = (int'(r_rr) + k) % NUM_SRC;
                    if (!w_gnt_v && idx != BR_SRC && w_head_ok[idx]) begin
                        w_gnt_v   = 1'b1;
                        w_gnt_idx = SRC_W'(idx);
                        nxt       = (idx + 1) % NUM_SRC;
                        if (nxt == BR_SRC) nxt = (nxt + 1) % NUM_SRC;
                        w_rr_nx   = SRC_W'(nxt);
                    end
                end
            end
        end
        w_gnt_pkt        = w_head[w_gnt_idx];
        w_gnt_pkt.src_fu = 2'(w_gnt_idx);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_out_v   <= 1'b0;
            r_out_pkt <= '0;
            r_rr      <= '0;
        end else begin
            r_rr <= w_rr_nx;
            if (w_load) begin
                r_out_v <= w_gnt_v;
                if (w_gnt_v) r_out_pkt <= w_gnt_pkt;
            end else if (w_out_kill) begin
                r_out_v <= 1'b0;
            end
        end
    end

    assign wb_valid_o  = r_out_v;
    assign wb_packet_o = r_out_pkt;
endmodule
